rom_port_arbiter: RTL and testbench



---
 rtl/rom_arb_pkg.sv | 11 +
 rtl/rom_port_arbiter_if.sv | 33 +++
 rtl/rom_arb_grant.sv | 44 ++++
 rtl/rom_port_arbiter.sv | 63 ++++++
 tb/tb_rom_port_arbiter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the instruction-ROM port arbiter.
package rom_arb_pkg;
   typedef enum logic [1:0] {
      OWNER_IDLE = 2'd0,
      OWNER_IF   = 2'd1,
      OWNER_LS   = 2'd2
   } owner_t;

   localparam int unsigned ROM_WORD_W = 32;
   localparam int unsigned BYTE_SHIFT = 2;
endpackage

// File: rtl/rom_port_arbiter_if.sv
// Requester handshakes and ROM port of the IF/LS instruction-ROM arbiter.
interface rom_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32
);
   import rom_arb_pkg::*;

   logic                  if_req_valid;
   logic [ADDR_W-1:0]     if_req_addr;
   logic                  if_req_ready;
   logic                  if_rsp_valid;
   logic [ROM_WORD_W-1:0] if_rsp_data;

   logic                  ls_req_valid;
   logic [ADDR_W-1:0]     ls_req_addr;
   logic                  ls_req_ready;
   logic                  ls_rsp_valid;
   logic [ROM_WORD_W-1:0] ls_rsp_data;

   logic [31:0]           rom_addr;
   logic [ROM_WORD_W-1:0] rom_r_data;

   modport slave (
      input  if_req_valid, if_req_addr, ls_req_valid, ls_req_addr, rom_r_data,
      output if_req_ready, if_rsp_valid, if_rsp_data,
      output ls_req_ready, ls_rsp_valid, ls_rsp_data, rom_addr
   );

   modport master (
      output if_req_valid, if_req_addr, ls_req_valid, ls_req_addr, rom_r_data,
      input  if_req_ready, if_rsp_valid, if_rsp_data,
      input  ls_req_ready, ls_rsp_valid, ls_rsp_data, rom_addr
   );
endinterface

// File: rtl/rom_arb_grant.sv
// Grant logic: LS over IF with a starvation guard, or round-robin on conflict
// when ROM_ARB_RR_EN is defined.
module rom_arb_grant #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic if_valid,
   input  logic ls_valid,
   output logic grant_if,
   output logic grant_ls
);
   logic if_wins;

`ifdef ROM_ARB_RR_EN
   // last_ls = 0 means IF won last, so LS takes the first conflict after reset
   logic last_ls;

   assign if_wins = last_ls;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)         last_ls <= 1'b0;
      else if (grant_if) last_ls <= 1'b0;
      else if (grant_ls) last_ls <= 1'b1;
   end
`else
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   logic [3:0] starve_cnt;

   assign if_wins = (starve_cnt == STARVE_LIM);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         starve_cnt <= '0;
      else if (if_valid && !grant_if)
         starve_cnt <= (starve_cnt == STARVE_LIM) ? STARVE_LIM : starve_cnt + 4'd1;
      else
         starve_cnt <= '0;
   end
`endif

   assign grant_if = if_valid & (~ls_valid | if_wins);
   assign grant_ls = ls_valid & ~grant_if;
endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one synchronous-read ROM between IF and LS; responses return one cycle
// after the grant. Optional round-robin arbitration via ROM_ARB_RR_EN.
module rom_port_arbiter
   import rom_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned BYTE_ADDR  = 1
) (
   input  logic                clock,
   input  logic                reset,
   rom_port_arbiter_if.slave   bus
);
   logic              grant_if;
   logic              grant_ls;
   logic [ADDR_W-1:0] sel_addr;
   logic [ADDR_W-1:0] word_addr;
   logic [31:0]       grant_addr;
   logic [31:0]       addr_shadow;
   owner_t            owner;

   rom_arb_grant #(
      .STARVE_MAX(STARVE_MAX)
   ) u_grant (
      .clock    (clock),
      .reset    (reset),
      .if_valid (bus.if_req_valid),
      .ls_valid (bus.ls_req_valid),
      .grant_if (grant_if),
      .grant_ls (grant_ls)
   );

   assign bus.if_req_ready = grant_if;
   assign bus.ls_req_ready = grant_ls;

   always_comb begin
      sel_addr   = grant_ls ? bus.ls_req_addr : bus.if_req_addr;
      word_addr  = (BYTE_ADDR != 0) ? (sel_addr >> BYTE_SHIFT) : sel_addr;
      grant_addr = 32'(word_addr);
   end

   // Without a grant the ROM keeps seeing the last address; its data is unowned
   assign bus.rom_addr = (grant_if | grant_ls) ? grant_addr : addr_shadow;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         owner       <= OWNER_IDLE;
         addr_shadow <= '0;
      end else begin
         if (grant_if)      owner <= OWNER_IF;
         else if (grant_ls) owner <= OWNER_LS;
         else               owner <= OWNER_IDLE;
         if (grant_if | grant_ls) addr_shadow <= grant_addr;
      end
   end

   always_comb begin
      bus.if_rsp_valid = (owner == OWNER_IF);
      bus.ls_rsp_valid = (owner == OWNER_LS);
      bus.if_rsp_data  = bus.if_rsp_valid ? bus.rom_r_data : '0;
      bus.ls_rsp_data  = bus.ls_rsp_valid ? bus.rom_r_data : '0;
   end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: a bench-side ROM and arbitration model
// predict grants, rom_addr and the one-cycle-later responses.
module tb_rom_port_arbiter;
   localparam int unsigned STARVE_MAX = 4;

   typedef struct packed {
      logic        ifv;
      logic        lsv;
      logic [31:0] data;
   } rsp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   rom_port_arbiter_if #(.ADDR_W(32)) bus ();

   rom_port_arbiter #(
      .ADDR_W     (32),
      .STARVE_MAX (STARVE_MAX),
      .BYTE_ADDR  (1)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] rom_fn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   always @(posedge clock) bus.rom_r_data <= rom_fn(bus.rom_addr);

   int   errors = 0;
   int   checks = 0;
   rsp_t exp_q[$];

   logic [3:0]  m_starve  = '0;
   logic        m_last_ls = 1'b0;
   logic [31:0] m_shadow  = '0;
   int          deny_run  = 0;
   int          max_deny  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_rsp();
      rsp_t e;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = '0;
      check_eq("if_rsp_valid", 32'(bus.if_rsp_valid), 32'(e.ifv));
      check_eq("if_rsp_data",  bus.if_rsp_data, e.ifv ? e.data : 32'h0);
      check_eq("ls_rsp_valid", 32'(bus.ls_rsp_valid), 32'(e.lsv));
      check_eq("ls_rsp_data",  bus.ls_rsp_data, e.lsv ? e.data : 32'h0);
   endtask

   task automatic model_grant(input logic ifv, input logic lsv, output logic gi, output logic gl);
      gi = 1'b0;
      gl = 1'b0;
      if (ifv && !lsv)      gi = 1'b1;
      else if (lsv && !ifv) gl = 1'b1;
      else if (ifv && lsv) begin
`ifdef ROM_ARB_RR_EN
         if (m_last_ls) gi = 1'b1; else gl = 1'b1;
`else
         if (m_starve == 4'(STARVE_MAX)) gi = 1'b1; else gl = 1'b1;
`endif
      end
   endtask

   task automatic step(input logic ifv, input logic [31:0] ifa, input logic lsv, input logic [31:0] lsa);
      logic        gi, gl;
      logic [31:0] exp_addr;
      rsp_t        e;
      @(negedge clock);
      check_rsp();
      bus.if_req_valid = ifv;
      bus.if_req_addr  = ifa;
      bus.ls_req_valid = lsv;
      bus.ls_req_addr  = lsa;
      #1;
      model_grant(ifv, lsv, gi, gl);
      exp_addr = gi ? (ifa >> 2) : gl ? (lsa >> 2) : m_shadow;
      check_eq("if_req_ready", 32'(bus.if_req_ready), 32'(gi));
      check_eq("ls_req_ready", 32'(bus.ls_req_ready), 32'(gl));
      check_eq("rom_addr", bus.rom_addr, exp_addr);
      e.ifv  = gi;
      e.lsv  = gl;
      e.data = rom_fn(exp_addr);
      exp_q.push_back(e);
      if (gi | gl) m_shadow = exp_addr;
      if (gi) m_last_ls = 1'b0;
      else if (gl) m_last_ls = 1'b1;
      if (ifv && !gi) m_starve = (m_starve == 4'(STARVE_MAX)) ? m_starve : m_starve + 4'd1;
      else            m_starve = '0;
      deny_run = (ifv && !bus.if_req_ready) ? deny_run + 1 : 0;
      if (deny_run > max_deny) max_deny = deny_run;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_if_rsp_valid"}, 32'(bus.if_rsp_valid), 32'h0);
      check_eq({tag, "_if_rsp_data"},  bus.if_rsp_data, 32'h0);
      check_eq({tag, "_ls_rsp_valid"}, 32'(bus.ls_rsp_valid), 32'h0);
      check_eq({tag, "_ls_rsp_data"},  bus.ls_rsp_data, 32'h0);
      check_eq({tag, "_rom_addr"},     bus.rom_addr, 32'h0);
      check_eq({tag, "_readies"},      {30'h0, bus.if_req_ready, bus.ls_req_ready}, 32'h0);
   endtask

   initial begin
      bus.if_req_valid = 1'b0;
      bus.if_req_addr  = '0;
      bus.ls_req_valid = 1'b0;
      bus.ls_req_addr  = '0;
      #3;
      check_all_zero("reset");
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      // IF-only stream, then an idle gap where rom_addr must hold
      step(1'b1, 32'h0, 1'b0, 32'h0);
      step(1'b1, 32'h4, 1'b0, 32'h0);
      step(1'b1, 32'h8, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 32'h0);

      // single-cycle conflict
      step(1'b1, 32'h10, 1'b1, 32'h20);
      step(1'b0, 32'h0, 1'b0, 32'h0);

      // sustained contention
      max_deny = 0;
      deny_run = 0;
      for (int i = 0; i < 15; i++)
         step(1'b1, 32'h100 + 32'(i * 4), 1'b1, 32'h200 + 32'(i * 4));
`ifdef ROM_ARB_RR_EN
      check_eq("if_max_denied", 32'(max_deny), 32'd1);
`else
      check_eq("if_max_denied", 32'(max_deny), 32'(STARVE_MAX));
`endif

      for (int i = 0; i < 40; i++)
         step(1'($urandom_range(1)), $urandom & 32'hFFFC,
              1'($urandom_range(1)), $urandom & 32'hFFFC);

      // reset during an in-flight LS response
      step(1'b0, 32'h0, 1'b1, 32'h40);
      @(posedge clock);
      #1;
      reset = 1'b1;
      bus.if_req_valid = 1'b0;
      bus.ls_req_valid = 1'b0;
      exp_q.delete();
      #1;
      check_all_zero("midreset");
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      reset     = 1'b0;
      m_starve  = '0;
      m_last_ls = 1'b0;
      m_shadow  = '0;
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b1, 32'h30, 1'b1, 32'h50);
      step(1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b0, 32'h0, 1'b0, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
